lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store memory controller between execute and data memory. Accepts one load/store per request.
//  Generates the word-aligned memory access, byte enables and replicated store data.
//  Returns the raw 32-bit read word plus the full byte address and instruction (drdata/daddr/idata) to the
//  downstream load-extract stage. Single outstanding access; valid/ready on the core side, req/gnt/rvalid on the memory side.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  DATA_W       32   data width (fixed 32; byte-lane logic assumes 4 lanes)
//  TIMEOUT_CYC  255  max cycles in REQ+WAIT before an error response (only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       execute presents a memory instruction
//  req_ready    out  1       controller can accept (IDLE only)
//  req_idata    in   32      instruction word (opcode [6:0], funct3 [14:12])
//  req_addr     in   ADDR_W  effective byte address (rs1+imm)
//  req_wdata    in   DATA_W  store data (rs2)
//  resp_valid   out  1       one-cycle response pulse
//  resp_idata   out  32      captured instruction, forwarded to load extract
//  resp_daddr   out  ADDR_W  captured full byte address
//  resp_drdata  out  DATA_W  raw memory word (loads); 0 for stores and errors
//  resp_err     out  1       misaligned, illegal funct3/opcode, or timeout
//  mem_req      out  1       memory request, held until mem_gnt
//  mem_we       out  1       1 = store
//  mem_addr     out  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}
//  mem_be       out  4       byte enables
//  mem_wdata    out  DATA_W  lane-replicated store data
//  mem_gnt      in   1       request accepted
//  mem_rvalid   in   1       read data valid / write ack (>=1 cycle after gnt)
//  mem_rdata    in   DATA_W  read word
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; all other outputs 0; timeout counter 0. Reset mid-access aborts the access, and a later mem_rvalid is ignored.
//  - FSM IDLE->REQ->WAIT->RESP->IDLE; IDLE->RESP directly on error-at-decode.
//  - IDLE: req_ready=1. On req_valid, capture idata/addr/wdata and decode:
//    load opcode 7'b0000011 with funct3 LB/LH/LW/LBU/LHU: mem_we=0, be=4'b1111
//    store opcode 7'b0100011 with funct3 SB/SH/SW: mem_we=1
//      SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}
//      SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}
//      SW: be=4'b1111, wdata=rs2
//    misaligned (H with addr[0]=1, W with addr[1:0]!=0), other funct3, or other opcode:
//      go to RESP with resp_err=1; no memory access
//  - REQ: mem_req=1 with stable addr/we/be/wdata until mem_gnt; on gnt -> WAIT, mem_req=0 next cycle.
//  - WAIT: on mem_rvalid, register mem_rdata (loads only) -> RESP. mem_rvalid outside WAIT is ignored.
//  - RESP: resp_valid=1 for exactly 1 cycle with idata/daddr/drdata/err; next state IDLE. The consumer never stalls.
//  - Latency: accept at T, mem_req at T+1; gnt at T+1 and rvalid at T+2 give resp_valid at T+3.
//    A decode error gives resp_valid at T+1. Back-to-back accept is possible the cycle after RESP.
//  - resp_* hold their last values when resp_valid=0; mem_addr/be/wdata are don't-care when mem_req=0.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: an 8+ bit counter runs in REQ/WAIT and clears on state entry.
//    Reaching TIMEOUT_CYC forces RESP with resp_err=1 and resp_drdata=0, deasserts mem_req,
//    and any late rvalid is ignored.
//  Undefined: no counter; REQ/WAIT wait indefinitely.
// TESTING
//  - LW addr 0x100, gnt same cycle, rvalid +1, rdata 0xDEADBEEF
//      -> mem_addr 0x100, be 4'hF, resp_valid at T+3, drdata 0xDEADBEEF, daddr 0x100, err 0
//  - SB addr 0x203, rs2 0x000000A5
//      -> mem_addr 0x200, be 4'b1000, wdata 0xA5A5A5A5, we 1, resp drdata 0, err 0
//  - SH addr 0x302 rs2 0x1234 -> be 4'b1100, wdata 0x12341234.
//    LH addr 0x301 -> no mem_req, resp_valid at T+1, err 1
//  - mem_gnt delayed 5 cycles -> mem_req and its fields stay stable for 5 cycles, req_ready 0 throughout;
//    a stray rvalid in IDLE produces no response
//  - Reset asserted in WAIT -> outputs 0 immediately, IDLE; a subsequent rvalid produces no resp_valid
//  - LSU_TIMEOUT_EN, TIMEOUT_CYC=8, no gnt -> resp_valid with err 1 after 8 cycles in REQ, mem_req drops

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: decodes one load/store, runs a single req/gnt/rvalid access and
// returns the raw read word with the captured instruction and address. Optional macro: LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_idata,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_idata,
    output logic [ADDR_W-1:0] resp_daddr,
    output logic [DATA_W-1:0] resp_drdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e            state;
    logic [31:0]       idata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              is_load_q;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CntW-1:0] cnt;
    logic            timeout;
    assign timeout = (cnt == CntW'(TIMEOUT_CYC - 1));
`endif

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [1:0]        lane;
    logic              dec_err;
    logic              dec_we;
    logic [3:0]        dec_be;
    logic [DATA_W-1:0] dec_wdata;

    assign opcode = req_idata[6:0];
    assign funct3 = req_idata[14:12];
    assign lane   = req_addr[1:0];

    always_comb begin
        dec_err   = 1'b1;
        dec_we    = 1'b0;
        dec_be    = 4'b1111;
        dec_wdata = req_wdata;
        if (opcode == OpLoad) begin
            case (funct3)
                3'b000, 3'b100: dec_err = 1'b0;
                3'b001, 3'b101: dec_err = lane[0];
                3'b010:         dec_err = (lane != 2'b00);
                default:        dec_err = 1'b1;
            endcase
        end else if (opcode == OpStore) begin
            dec_we = 1'b1;
            case (funct3)
                3'b000: begin
                    dec_err   = 1'b0;
                    dec_be    = 4'b0001 << lane;
                    dec_wdata = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    dec_err   = lane[0];
                    dec_be    = 4'b0011 << lane;
                    dec_wdata = {2{req_wdata[15:0]}};
                end
                3'b010:  dec_err = (lane != 2'b00);
                default: dec_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_idata  <= '0;
            resp_daddr  <= '0;
            resp_drdata <= '0;
            resp_err    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            idata_q     <= '0;
            addr_q      <= '0;
            is_load_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        idata_q   <= req_idata;
                        addr_q    <= req_addr;
                        is_load_q <= ~dec_we;
                        mem_we    <= dec_we;
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= dec_be;
                        mem_wdata <= dec_wdata;
`ifdef LSU_TIMEOUT_EN
                        cnt       <= '0;
`endif
                        if (dec_err) begin
                            state       <= StResp;
                            resp_valid  <= 1'b1;
                            resp_err    <= 1'b1;
                            resp_drdata <= '0;
                            resp_idata  <= req_idata;
                            resp_daddr  <= req_addr;
                        end else begin
                            state   <= StReq;
                            mem_req <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        state   <= StWait;
                        mem_req <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        cnt     <= '0;
                    end else if (timeout) begin
                        state       <= StResp;
                        mem_req     <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b1;
                        resp_drdata <= '0;
                        resp_idata  <= idata_q;
                        resp_daddr  <= addr_q;
                    end else begin
                        cnt <= cnt + CntW'(1);
`endif
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state       <= StResp;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b0;
                        resp_drdata <= is_load_q ? mem_rdata : '0;
                        resp_idata  <= idata_q;
                        resp_daddr  <= addr_q;
`ifdef LSU_TIMEOUT_EN
                    end else if (timeout) begin
                        state       <= StResp;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b1;
                        resp_drdata <= '0;
                        resp_idata  <= idata_q;
                        resp_daddr  <= addr_q;
                    end else begin
                        cnt <= cnt + CntW'(1);
`endif
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
